// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, pipeline depth and response tag type for the CORDIC arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cordic_pkg;

  localparam int ANGLE_W        = 17;
  localparam int DATA_W         = 16;
  localparam int CORDIC_LATENCY = 17;

  // Tag id is sized for up to 256 requesters; the arbiter uses only the low bits it needs.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// cordic_rr_arbiter: one-hot round-robin pick from a request vector and a "positions after last winner" mask.
// Latency: purely combinational.
// Backpressure: none; a zero request vector yields a zero grant.
module cordic_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] Req,
  input  logic [N-1:0] Mask,
  output logic [N-1:0] Grant
);

  logic [N-1:0] masked_req;
  logic [N-1:0] grant_masked;
  logic [N-1:0] grant_plain;
  logic         found_masked;
  logic         found_plain;

  // Lowest-index requester above the last winner wins; if none, wrap to the lowest requester overall.
  always_comb begin
    masked_req   = Req & Mask;
    grant_masked = '0;
    grant_plain  = '0;
    found_masked = 1'b0;
    found_plain  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (masked_req[i] && !found_masked) begin
        grant_masked[i] = 1'b1;
        found_masked    = 1'b1;
      end
      if (Req[i] && !found_plain) begin
        grant_plain[i] = 1'b1;
        found_plain    = 1'b1;
      end
    end
    Grant = found_masked ? grant_masked : grant_plain;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one CORDIC pipeline among NUM_REQ requesters, with response routing.
// Latency: transfer -> Core_valid 1 cycle; transfer -> Rsp_valid LATENCY+1 cycles.
// Backpressure: Req_ready withheld while a requester has MAX_OUT in flight; responses are never stalled.
// Build option CORDIC_ARB_STATS_EN adds per-requester saturating grant counters (Stat_sel / Stat_grants).
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int MAX_OUT = 8
) (
  input  logic                                        Clk,
  input  logic                                        Reset_n,
  input  logic [NUM_REQ-1:0]                          Req_valid,
  input  logic [NUM_REQ*ANGLE_W-1:0]                  Req_angle,
  output logic [NUM_REQ-1:0]                          Req_ready,
  output logic                                        Core_valid,
  output logic [ANGLE_W-1:0]                          Core_angle,
  input  logic signed [DATA_W-1:0]                    Core_cos,
  input  logic signed [DATA_W-1:0]                    Core_sin,
  output logic [NUM_REQ-1:0]                          Rsp_valid,
  output logic signed [DATA_W-1:0]                    Rsp_cos,
  output logic signed [DATA_W-1:0]                    Rsp_sin,
  output logic                                        Busy
`ifdef CORDIC_ARB_STATS_EN
  ,
  input  logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] Stat_sel,
  output logic [31:0]                                 Stat_grants
`endif
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]  rr_mask;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  xfer_vec;
  logic                xfer;
  logic [ANGLE_W-1:0]  grant_angle;
  logic [ID_W-1:0]     grant_id;
  logic [TAG_ID_W-1:0] core_id;
  logic [CNT_W-1:0]    out_cnt [NUM_REQ];
  tag_t                tag_sr  [LATENCY];
  tag_t                tag_out;

  // Eligibility and round-robin mask; a response retiring this cycle frees its slot for an immediate re-grant.
  always_comb begin
    rr_mask  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_mask[i]  = (ID_W'(i) > last_grant);
      eligible[i] = Req_valid[i] && ((out_cnt[i] < CNT_W'(MAX_OUT)) || Rsp_valid[i]);
    end
  end

  cordic_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .Req   (eligible),
    .Mask  (rr_mask),
    .Grant (grant)
  );

  assign Req_ready = grant;
  assign xfer_vec  = Req_valid & grant;
  assign xfer      = |xfer_vec;

  // Mux out the winner's angle and encode its index.
  always_comb begin
    grant_angle = '0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_angle = Req_angle[i*ANGLE_W +: ANGLE_W];
        grant_id    = ID_W'(i);
      end
    end
  end

  // Issue register toward the core; pointer starts at the top index so requester 0 wins first.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Core_valid <= 1'b0;
      Core_angle <= '0;
      core_id    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      Core_valid <= xfer;
      if (xfer) begin
        Core_angle <= grant_angle;
        core_id    <= TAG_ID_W'(grant_id);
        last_grant <= grant_id;
      end
    end
  end

  // Tag pipeline tracks the core: one entry per cycle, valid only when an angle was issued.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_sr[k] <= '0;
      end
    end else begin
      tag_sr[0].valid <= Core_valid;
      tag_sr[0].id    <= core_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_sr[k] <= tag_sr[k-1];
      end
    end
  end

  assign tag_out = tag_sr[LATENCY-1];

  // Route the core result to the owner of the tag leaving the pipeline; zero the data otherwise.
  always_comb begin
    Rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      Rsp_valid[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
    end
    Rsp_cos = (|Rsp_valid) ? Core_cos : '0;
    Rsp_sin = (|Rsp_valid) ? Core_sin : '0;
  end

  // Busy while any tag is still travelling through the pipeline.
  always_comb begin
    Busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      Busy = Busy | tag_sr[k].valid;
    end
  end

  // Per-requester in-flight count: up on transfer, down on response, unchanged when both coincide.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({xfer_vec[i], Rsp_valid[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + CNT_W'(1);
          2'b01:   out_cnt[i] <= out_cnt[i] - CNT_W'(1);
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

`ifdef CORDIC_ARB_STATS_EN
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [31:0] grant_cnt [NUM_REQ];

  // Saturating grant counters, one per requester.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer_vec[i] && (grant_cnt[i] != 32'hFFFF_FFFF)) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Read port for the selected counter; out-of-range selects read as zero.
  always_comb begin
    Stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (Stat_sel == SEL_W'(i)) begin
        Stat_grants = grant_cnt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: randomized and directed checks of cordic_arbiter against a queue-based reference model.
// Latency: the bench core model returns results LATENCY cycles after Core_valid.
// Backpressure: responses are consumed unconditionally by the bench.
`timescale 1ns/1ps
module tb_cordic_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 17;
  localparam int MO  = 2;
  localparam int AW  = 17;
  localparam int VW  = NR + 1 + AW + NR + 16 + 16 + 1;

  logic                Clk = 1'b0;
  logic                Reset_n;
  logic [NR-1:0]       Req_valid;
  logic [NR*AW-1:0]    Req_angle;
  logic [NR-1:0]       Req_ready;
  logic                Core_valid;
  logic [AW-1:0]       Core_angle;
  logic signed [15:0]  Core_cos;
  logic signed [15:0]  Core_sin;
  logic [NR-1:0]       Rsp_valid;
  logic signed [15:0]  Rsp_cos;
  logic signed [15:0]  Rsp_sin;
  logic                Busy;
`ifdef CORDIC_ARB_STATS_EN
  logic [1:0]          Stat_sel = 2'd0;
  logic [31:0]         Stat_grants;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  cordic_arbiter #(
    .NUM_REQ (NR),
    .LATENCY (LAT),
    .MAX_OUT (MO)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Req_valid  (Req_valid),
    .Req_angle  (Req_angle),
    .Req_ready  (Req_ready),
    .Core_valid (Core_valid),
    .Core_angle (Core_angle),
    .Core_cos   (Core_cos),
    .Core_sin   (Core_sin),
    .Rsp_valid  (Rsp_valid),
    .Rsp_cos    (Rsp_cos),
    .Rsp_sin    (Rsp_sin),
    .Busy       (Busy)
`ifdef CORDIC_ARB_STATS_EN
    ,
    .Stat_sel    (Stat_sel),
    .Stat_grants (Stat_grants)
`endif
  );

  // Distinct, easily predicted core results per angle.
  function automatic logic [15:0] cos_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] sin_of(input logic [AW-1:0] a);
    return {a[16:2], a[0]} + 16'h1234;
  endfunction

  function automatic logic [NR*AW-1:0] rand_angles();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[NR*AW-1:0];
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Stand-in CORDIC core: a delay line that is not reset and emits noise when idle.
  logic [LAT-1:0] core_pv = '0;
  logic [AW-1:0]  core_pa [LAT];
  logic [31:0]    noise = 32'h1;

  always @(posedge Clk) begin
    core_pv    <= {core_pv[LAT-2:0], Core_valid};
    core_pa[0] <= Core_angle;
    for (int k = 1; k < LAT; k++) core_pa[k] <= core_pa[k-1];
    noise <= $urandom;
  end

  assign Core_cos = core_pv[LAT-1] ? cos_of(core_pa[LAT-1]) : noise[15:0];
  assign Core_sin = core_pv[LAT-1] ? sin_of(core_pa[LAT-1]) : noise[31:16];

  // Reference model: requests become queue entries retiring LATENCY+1 cycles after their transfer.
  typedef struct {
    int            t;
    int            id;
    logic [AW-1:0] ang;
  } pend_t;

  pend_t         pq [$];
  int            m_last;
  int            m_cnt [NR];
  logic          m_cv;
  logic [AW-1:0] m_ca;
  int            cyc;
  int            g_idx;
  int            r_pos;
  logic [AW-1:0] g_ang;
  logic [VW-1:0] exp_vec;

  wire [VW-1:0] obs = {Req_ready, Core_valid, Core_angle, Rsp_valid, Rsp_cos, Rsp_sin, Busy};

  task automatic model_reset();
    pq.delete();
    m_last = NR - 1;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_cv = 1'b0;
    m_ca = '0;
  endtask

  task automatic model_eval(input logic [NR-1:0] v, input logic [NR*AW-1:0] a);
    logic [NR-1:0] e_ready;
    logic [NR-1:0] e_rsp;
    logic [15:0]   e_cos;
    logic [15:0]   e_sin;
    logic          e_busy;
    int            idx;
    int            eff;
    r_pos  = -1;
    e_busy = 1'b0;
    for (int j = 0; j < pq.size(); j++) begin
      if (pq[j].t + LAT + 1 == cyc) r_pos = j;
      if (cyc >= pq[j].t + 2) e_busy = 1'b1;
    end
    g_idx = -1;
    g_ang = '0;
    for (int k = 1; k <= NR; k++) begin
      idx = (m_last + k) % NR;
      eff = m_cnt[idx] - (((r_pos >= 0) && (pq[r_pos].id == idx)) ? 1 : 0);
      if (g_idx < 0 && v[idx] && eff < MO) g_idx = idx;
    end
    e_ready = '0;
    if (g_idx >= 0) begin
      e_ready[g_idx] = 1'b1;
      g_ang = a[g_idx*AW +: AW];
    end
    e_rsp = '0;
    e_cos = '0;
    e_sin = '0;
    if (r_pos >= 0) begin
      e_rsp[pq[r_pos].id] = 1'b1;
      e_cos = cos_of(pq[r_pos].ang);
      e_sin = sin_of(pq[r_pos].ang);
    end
    exp_vec = {e_ready, m_cv, m_ca, e_rsp, e_cos, e_sin, e_busy};
  endtask

  task automatic model_commit();
    pend_t p;
    if (r_pos >= 0) begin
      m_cnt[pq[r_pos].id]--;
      pq.delete(r_pos);
    end
    if (g_idx >= 0) begin
      m_cnt[g_idx]++;
      m_last = g_idx;
      p.t = cyc;
      p.id = g_idx;
      p.ang = g_ang;
      pq.push_back(p);
      m_cv = 1'b1;
      m_ca = g_ang;
    end else begin
      m_cv = 1'b0;
    end
    cyc++;
  endtask

  // Drive a cycle's inputs, then evaluate the model at the falling edge.
  task automatic step_begin(input logic [NR-1:0] v, input logic [NR*AW-1:0] a);
    Req_valid = v;
    Req_angle = a;
    @(negedge Clk);
    model_eval(v, a);
  endtask

  task automatic step_end();
    model_commit();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset_n   = 1'b0;
    Req_valid = '0;
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n   = 1'b0;
    Req_valid = '0;
    Req_angle = '0;
    cyc       = 0;
    model_reset();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({Core_valid, Core_angle, Rsp_valid, Busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got cv=%b ang=%h rsp=%b busy=%b, expected all zero",
               Core_valid, Core_angle, Rsp_valid, Busy);
    end
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      step_begin('0, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      step_end();
    end
  endtask

  task automatic test_single();
    logic [NR*AW-1:0] a;
    int               t_cv;
    int               t_rsp;
    logic [NR-1:0]    rsp_seen;
    logic [31:0]      data_seen;
    t_cv      = -1;
    t_rsp     = -1;
    rsp_seen  = '0;
    data_seen = '0;
    for (int c = 0; c < 22; c++) begin
      a = rand_angles();
      a[2*AW +: AW] = 17'h04000;
      step_begin((c == 0) ? 4'b0100 : 4'b0000, a);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL single cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      if (Core_valid && t_cv < 0) t_cv = c;
      if ((Rsp_valid != '0) && t_rsp < 0) begin
        t_rsp     = c;
        rsp_seen  = Rsp_valid;
        data_seen = {Rsp_cos, Rsp_sin};
      end
      step_end();
    end
    checks++;
    if (t_cv != 1) begin
      errors++;
      $display("FAIL single_core_valid_cycle: got %0d expected 1", t_cv);
    end
    checks++;
    if (t_rsp != 18 || rsp_seen !== 4'b0100) begin
      errors++;
      $display("FAIL single_rsp: got cycle %0d rsp %b expected cycle 18 rsp 0100", t_rsp, rsp_seen);
    end
    checks++;
    if (data_seen !== {cos_of(17'h04000), sin_of(17'h04000)}) begin
      errors++;
      $display("FAIL single_rsp_data: got %h expected %h", data_seen,
               {cos_of(17'h04000), sin_of(17'h04000)});
    end
  endtask

  task automatic test_fairness();
    logic [31:0] g_order;
    logic [31:0] r_order;
    g_order = 32'hFFFF_FFFF;
    r_order = 32'hFFFF_FFFF;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      step_begin((c < 8) ? 4'b1111 : 4'b0000, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL fairness cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      if (Req_ready != '0) g_order = {g_order[27:0], 4'(onehot_idx(Req_ready))};
      if (Rsp_valid != '0) r_order = {r_order[27:0], 4'(onehot_idx(Rsp_valid))};
      step_end();
    end
    checks++;
    if (g_order !== 32'h0123_0123) begin
      errors++;
      $display("FAIL fairness_grant_order: got %h expected 01230123", g_order);
    end
    checks++;
    if (r_order !== 32'h0123_0123) begin
      errors++;
      $display("FAIL fairness_rsp_order: got %h expected 01230123", r_order);
    end
  endtask

  task automatic test_credit();
    logic [18:0] rdy_seen;
    rdy_seen = '0;
    apply_reset();
    for (int c = 0; c < 42; c++) begin
      step_begin((c <= 20) ? 4'b0010 : 4'b0000, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL credit cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      if (c <= 18) rdy_seen[c] = Req_ready[1];
      step_end();
    end
    checks++;
    if (rdy_seen !== 19'h40003) begin
      errors++;
      $display("FAIL credit_ready_pattern: got %h expected 40003", rdy_seen);
    end
  endtask

  task automatic test_simultaneous();
    logic v0;
    for (int c = 0; c < 40; c++) begin
      v0 = (c == 0) || (c >= 18 && c <= 21);
      step_begin({3'b000, v0}, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL simultaneous cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      if (c == 18) begin
        checks++;
        if ({Rsp_valid, Req_ready} !== 8'b0001_0001) begin
          errors++;
          $display("FAIL simult_rsp_and_grant: got rsp=%b rdy=%b expected 0001/0001", Rsp_valid, Req_ready);
        end
      end
      if (c == 19 || c == 20) begin
        checks++;
        if (Req_ready !== ((c == 19) ? 4'b0001 : 4'b0000)) begin
          errors++;
          $display("FAIL simult_count_hold cycle %0d: got rdy=%b", c, Req_ready);
        end
      end
      step_end();
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] rsp_seen;
    rsp_seen = '0;
    for (int c = 0; c < 8; c++) begin
      step_begin((c < 5) ? 4'b1111 : 4'b0000, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_fill cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      step_end();
    end
    Req_valid = '0;
    Reset_n   = 1'b0;
    #1;
    checks++;
    if ({Busy, Core_valid, Rsp_valid} !== '0) begin
      errors++;
      $display("FAIL reset_mid_immediate: got busy=%b cv=%b rsp=%b expected zero", Busy, Core_valid, Rsp_valid);
    end
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    cyc++;
    for (int c = 0; c < 20; c++) begin
      step_begin('0, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      rsp_seen = rsp_seen | Rsp_valid;
      step_end();
    end
    checks++;
    if (rsp_seen !== '0) begin
      errors++;
      $display("FAIL reset_mid_no_rsp: got %b expected 0000", rsp_seen);
    end
    step_begin(4'b1111, rand_angles());
    checks++;
    if (Req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_first_grant: got %b expected 0001", Req_ready);
    end
    step_end();
    for (int c = 0; c < 20; c++) begin
      step_begin('0, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_drain cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      step_end();
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] v;
    for (int c = 0; c < 420; c++) begin
      v = (c < 400) ? NR'($urandom_range(0, 15) | $urandom_range(0, 15)) : '0;
      if (c < 400 && (c % 50) < 10) v = 4'b1111;
      step_begin(v, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      step_end();
    end
  endtask

`ifdef CORDIC_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      step_begin((c <= 18) ? 4'b1000 : 4'b0000, rand_angles());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL stats_traffic cycle %0d: got %h expected %h", c, obs, exp_vec);
      end
      step_end();
    end
    Stat_sel = 2'd3;
    #1;
    checks++;
    if (Stat_grants !== 32'd3) begin
      errors++;
      $display("FAIL stats_sel3: got %0d expected 3", Stat_grants);
    end
    Stat_sel = 2'd0;
    #1;
    checks++;
    if (Stat_grants !== 32'd0) begin
      errors++;
      $display("FAIL stats_sel0: got %0d expected 0", Stat_grants);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_credit();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef CORDIC_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one CORDIC pipeline.
REQ-002 SHALL have parameter LATENCY, default 17, cycles from Core_valid to matching Core_cos/Core_sin.
REQ-003 SHALL have parameter MAX_OUT, default 8, per-requester limit on in-flight requests.
REQ-004 SHALL have ports:
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req_valid  in  NUM_REQ  per-requester request valid.
- Req_angle  in  NUM_REQ*17  packed angles; requester i at bits [17i+16:17i].
- Req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
- Core_valid  out  1  angle issued to core this cycle.
- Core_angle  out  17  issued angle.
- Core_cos  in  16  signed core cosine result.
- Core_sin  in  16  signed core sine result.
- Rsp_valid  out  NUM_REQ  one-hot result strobe.
- Rsp_cos  out  16  signed routed cosine.
- Rsp_sin  out  16  signed routed sine.
- Busy  out  1  any request in flight.

Function
REQ-005 SHALL arbitrate round-robin: search starts at last-granted index + 1 and wraps modulo NUM_REQ.
REQ-006 SHALL treat requester i as eligible only when Req_valid[i]=1 and its outstanding count < MAX_OUT.
REQ-007 SHALL drive Req_ready combinationally; a transfer occurs when Req_valid[i] and Req_ready[i] are both high; at most one transfer per cycle.
REQ-008 SHALL update the round-robin pointer only on a transfer.
REQ-009 SHALL register the granted angle: Core_valid=1 and Core_angle=granted angle in the cycle after the transfer; otherwise Core_valid=0 and Core_angle holds its value.
REQ-010 SHALL push a tag {valid, requester id} into a LATENCY-deep shift register in the same cycle Core_valid=1, and push an invalid tag otherwise.
REQ-011 SHALL assert Rsp_valid[id] exactly LATENCY cycles after the corresponding Core_valid, giving a total of LATENCY+1 cycles from transfer to response.
REQ-012 SHALL pass Rsp_cos/Rsp_sin combinationally from Core_cos/Core_sin when any Rsp_valid bit is high, and drive 0 otherwise.
REQ-013 SHALL keep a per-requester outstanding counter, width clog2(MAX_OUT+1):
- +1 on transfer.
- -1 on Rsp_valid.
- Unchanged when both occur in the same cycle.
REQ-014 SHALL drive Busy=1 whenever any tag stage is valid.
REQ-015 SHALL have no response backpressure; requesters accept Rsp_valid unconditionally.

Reset
REQ-016 SHALL clear, on Reset_n low and asynchronously: all tags, counters, Core_valid, Core_angle, and Busy to 0; the pointer to NUM_REQ-1 so requester 0 wins first.
REQ-017 SHALL discard in-flight requests when reset occurs mid-operation; core results arriving afterwards produce no Rsp_valid.

Configuration
REQ-018 SHALL, with CORDIC_ARB_STATS_EN defined:
- Add ports Stat_sel (in, clog2(NUM_REQ)) and Stat_grants (out, 32).
- Keep a saturating 32-bit grant counter per requester, cleared by reset.
- Drive Stat_grants with the counter selected by Stat_sel.
REQ-019 SHALL, without CORDIC_ARB_STATS_EN, omit these ports and counters; behaviour is otherwise identical.

Structure
REQ-020 SHALL place ANGLE_W=17, DATA_W=16, CORDIC_LATENCY=17 and the tag typedef {valid, id} in shared package cordic_pkg.
REQ-021 SHALL implement round-robin selection in sub-module cordic_rr_arbiter (request and mask vectors in, one-hot grant out).

Verification
REQ-022 Single request: requester 2 sends angle 17'h04000 at cycle 0.
- Required: Core_valid at cycle 1.
- Required: Rsp_valid=4'b0100 at cycle 18 with core outputs routed.
REQ-023 Fairness: all four requesters hold valid for 8 cycles.
- Required: grant order 0,1,2,3,0,1,2,3.
- Required: each receives 2 responses in that order.
REQ-024 Credit limit: MAX_OUT=2, requester 1 always valid, others idle.
- Required: two grants, then Req_ready[1]=0 until the first response, then one new grant in that cycle.
REQ-025 Simultaneous events: requester 0 transfers in the cycle its earlier response returns.
- Required: counter unchanged.
- Required: Rsp_valid=4'b0001 that cycle.
REQ-026 Reset mid-operation: assert Reset_n=0 for 1 cycle with 5 requests in flight.
- Required: Busy=0 immediately.
- Required: no Rsp_valid for the following 20 cycles.
- Required: the next grant goes to requester 0.
REQ-027 Stats (CORDIC_ARB_STATS_EN): 3 grants to requester 3, Stat_sel=3.
- Required: Stat_grants=3.
- Required: Stat_sel=0 gives 0.
